// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle: WB + mult/div inputs, RF write outputs.
// RF_WRITE_SCOREBOARD_EN adds the mult/div busy scoreboard signals.
interface rf_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wbWrite;
   logic [ADDR_W-1:0] wbAddr;
   logic [DATA_W-1:0] wbData;
   logic              auxValid;
   logic [ADDR_W-1:0] auxAddr;
   logic [DATA_W-1:0] auxData;
   logic              auxReady;
   logic              rfWrite;
   logic [ADDR_W-1:0] rfAddr;
   logic [DATA_W-1:0] rfData;
   logic              pipeStall;
   logic              pending;
`ifdef RF_WRITE_SCOREBOARD_EN
   logic              issueValid;
   logic [ADDR_W-1:0] issueAddr;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic              rsBusy;
   logic              rtBusy;
`endif

   modport master (
`ifdef RF_WRITE_SCOREBOARD_EN
      output issueValid, issueAddr, rs, rt,
      input  rsBusy, rtBusy,
`endif
      output wbWrite, wbAddr, wbData,
      output auxValid, auxAddr, auxData,
      input  auxReady, rfWrite, rfAddr, rfData,
      input  pipeStall, pending
   );

   modport slave (
`ifdef RF_WRITE_SCOREBOARD_EN
      input  issueValid, issueAddr, rs, rt,
      output rsBusy, rtBusy,
`endif
      input  wbWrite, wbAddr, wbData,
      input  auxValid, auxAddr, auxData,
      output auxReady, rfWrite, rfAddr, rfData,
      output pipeStall, pending
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Single RF write port shared by WB (primary) and buffered mult/div results.
// Optional busy scoreboard enabled by defining RF_WRITE_SCOREBOARD_EN.
module rf_write_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 4
) (
   input logic          clk,
   input logic          rst,
   rf_write_arbiter_if.slave bus
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic {RUN, STALL} state_t;

   logic [ADDR_W-1:0] r_fAddr [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fData [FIFO_DEPTH];
   logic [PW-1:0]     r_rdPtr;
   logic [PW-1:0]     r_wrPtr;
   logic [CW-1:0]     r_count;
   logic [WW-1:0]     r_waitCnt;
   state_t            r_state;
   state_t            w_next;
   logic              r_rfWrite;
   logic [ADDR_W-1:0] r_rfAddr;
   logic [DATA_W-1:0] r_rfData;
   logic              w_pri;
   logic              w_push;
   logic              w_pop;
   logic              w_nonEmpty;
   logic              w_ready;
   logic              w_stall;

   assign w_nonEmpty = (r_count != '0);
   assign w_ready    = (r_count < CW'(FIFO_DEPTH)) & ~rst;
   assign w_pri      = bus.wbWrite & (bus.wbAddr != '0);
   assign w_push     = bus.auxValid & w_ready & (bus.auxAddr != '0);
   // Only entries already stored can be granted; no same-cycle bypass.
   assign w_pop      = ~w_pri & w_nonEmpty;

   assign bus.auxReady  = w_ready;
   assign bus.rfWrite   = r_rfWrite;
   assign bus.rfAddr    = r_rfAddr;
   assign bus.rfData    = r_rfData;
   assign bus.pipeStall = w_stall;
   assign bus.pending   = w_nonEmpty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fAddr[r_wrPtr] <= bus.auxAddr;
         r_fData[r_wrPtr] <= bus.auxData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rfWrite <= 1'b0;
         r_rfAddr  <= '0;
         r_rfData  <= '0;
      end else if (w_pri) begin
         r_rfWrite <= 1'b1;
         r_rfAddr  <= bus.wbAddr;
         r_rfData  <= bus.wbData;
      end else if (w_pop) begin
         r_rfWrite <= 1'b1;
         r_rfAddr  <= r_fAddr[r_rdPtr];
         r_rfData  <= r_fData[r_rdPtr];
      end else begin
         r_rfWrite <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waitCnt <= '0;
      end else if (w_pop) begin
         r_waitCnt <= '0;
      end else if (w_nonEmpty && w_pri &&
                   r_waitCnt != WW'(MAX_WAIT)) begin
         r_waitCnt <= r_waitCnt + WW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RUN: begin
            if (r_waitCnt == WW'(MAX_WAIT)) w_next = STALL;
         end
         STALL: begin
            if (w_pop || !w_nonEmpty) w_next = RUN;
         end
         default: w_next = RUN;
      endcase
   end

   always_comb begin
      w_stall = 1'b0;
      unique case (r_state)
         STALL:   w_stall = 1'b1;
         default: w_stall = 1'b0;
      endcase
   end

`ifdef RF_WRITE_SCOREBOARD_EN
   localparam int NREG = 1 << ADDR_W;

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busyNext;

   // Clear before set so a same-cycle issue to the granted address wins.
   always_comb begin
      w_busyNext = r_busy;
      if (w_pop) w_busyNext[r_fAddr[r_rdPtr]] = 1'b0;
      if (bus.issueValid && bus.issueAddr != '0)
         w_busyNext[bus.issueAddr] = 1'b1;
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busyNext;
   end

   assign bus.rsBusy = r_busy[bus.rs];
   assign bus.rtBusy = r_busy[bus.rt];
`endif
endmodule
